// File: rtl/clk_divider_bank.sv
// Bank of independent programmable clock dividers producing per-channel strobes and
// square-type waves, with glitch-free divider updates at period boundaries and global re-sync.
module clk_divider_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 32,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [DIV_W-1:0]  i_wr_div,
  input  logic              i_wr_run,
  input  logic              i_wr_oneshot,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_strobe,
  output logic [NUM_CH-1:0] o_wave,
  output logic [NUM_CH-1:0] o_active,
  output logic [NUM_CH-1:0] o_pending
);

  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_n [NUM_CH];
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_n [NUM_CH];
  logic [DIV_W-1:0] shd_q [NUM_CH];
  logic [DIV_W-1:0] shd_n [NUM_CH];

  // run: a strobe has occurred since the last (re)start, so the wave may be high.
  // tail: oneshot channel finishing its wave high phase after going inactive.
  logic [NUM_CH-1:0] act_q, act_n, pend_q, pend_n, one_q, one_n;
  logic [NUM_CH-1:0] run_q, run_n, tail_q, tail_n;
  logic [NUM_CH-1:0] strobe_q, strobe_n, wave_q, wave_n;
  logic [NUM_CH-1:0] hit, bound;
  logic              wr_dis;

  // Next-state: count/boundary first, then sync, then the write, then wave decode.
  always_comb begin
    cnt_n    = cnt_q;
    div_n    = div_q;
    shd_n    = shd_q;
    act_n    = act_q;
    pend_n   = pend_q;
    one_n    = one_q;
    run_n    = run_q;
    tail_n   = tail_q;
    strobe_n = '0;
    wave_n   = '0;
    hit      = '0;
    bound    = '0;
    wr_dis   = (!i_wr_run) || (i_wr_div < DIV_W'(2));
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      hit[c]   = i_wr_en && (i_wr_ch == CH_W'(c));
      bound[c] = act_q[c] && !i_sync && (cnt_q[c] == div_q[c] - DIV_W'(1));
      if (act_q[c] && i_sync) begin
        cnt_n[c] = '0;
        run_n[c] = 1'b0;
        if (pend_q[c]) begin
          div_n[c]  = shd_q[c];
          pend_n[c] = 1'b0;
        end
      end else if (bound[c]) begin
        strobe_n[c] = 1'b1;
        cnt_n[c]    = '0;
        run_n[c]    = 1'b1;
        if (pend_q[c]) begin
          div_n[c]  = shd_q[c];
          pend_n[c] = 1'b0;
        end
        if (one_q[c]) begin
          act_n[c]  = 1'b0;
          tail_n[c] = 1'b1;
        end
      end else if (act_q[c] || tail_q[c]) begin
        cnt_n[c] = cnt_q[c] + DIV_W'(1);
      end
      if (i_sync) begin
        tail_n[c] = 1'b0;
      end
      if (hit[c]) begin
        if (wr_dis) begin
          act_n[c]    = 1'b0;
          tail_n[c]   = 1'b0;
          pend_n[c]   = 1'b0;
          run_n[c]    = 1'b0;
          one_n[c]    = 1'b0;
          strobe_n[c] = 1'b0;
          cnt_n[c]    = '0;
        end else if (!act_q[c]) begin
          act_n[c]  = 1'b1;
          tail_n[c] = 1'b0;
          pend_n[c] = 1'b0;
          run_n[c]  = 1'b0;
          one_n[c]  = i_wr_oneshot;
          div_n[c]  = i_wr_div;
          cnt_n[c]  = '0;
        end else begin
          one_n[c] = i_wr_oneshot;
          // On a boundary or a sync edge the new ratio governs the period starting now.
          if (bound[c] || i_sync) begin
            div_n[c]  = i_wr_div;
            pend_n[c] = 1'b0;
          end else begin
            shd_n[c]  = i_wr_div;
            pend_n[c] = 1'b1;
          end
        end
      end
      if (tail_n[c] && (cnt_n[c] >= (div_n[c] >> 1))) begin
        tail_n[c] = 1'b0;
        cnt_n[c]  = '0;
      end
      wave_n[c] = ((act_n[c] && run_n[c]) || tail_n[c]) && (cnt_n[c] < (div_n[c] >> 1));
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= '0;
        shd_q[c] <= '0;
      end
      act_q    <= '0;
      pend_q   <= '0;
      one_q    <= '0;
      run_q    <= '0;
      tail_q   <= '0;
      strobe_q <= '0;
      wave_q   <= '0;
    end else begin
      cnt_q    <= cnt_n;
      div_q    <= div_n;
      shd_q    <= shd_n;
      act_q    <= act_n;
      pend_q   <= pend_n;
      one_q    <= one_n;
      run_q    <= run_n;
      tail_q   <= tail_n;
      strobe_q <= strobe_n;
      wave_q   <= wave_n;
    end
  end

  assign o_strobe  = strobe_q;
  assign o_wave    = wave_q;
  assign o_active  = act_q;
  assign o_pending = pend_q;

endmodule
